// File: rtl/column_scheduler_if.sv
// column_scheduler_if: control/status bundle between the game top level, the scheduler and its columns
interface column_scheduler_if #(
  parameter int NUM_COLUMNS = 4
);
  logic                   start;
  logic [NUM_COLUMNS-1:0] col_correct;
  logic [NUM_COLUMNS-1:0] col_game_over;
  logic [NUM_COLUMNS-1:0] col_hold;
  logic                   fall_tick;
  logic [15:0]            score;
  logic [3:0]             level;
  logic [1:0]             state;
  logic                   game_over;
  modport master (
    output start, col_correct, col_game_over,
    input  col_hold, fall_tick, score, level, state, game_over
  );
  modport slave (
    input  start, col_correct, col_game_over,
    output col_hold, fall_tick, score, level, state, game_over
  );
endinterface

// File: rtl/column_scheduler.sv
// column_scheduler: game sequencer, fall-tick generator and score/level keeper for falling-letter columns
module column_scheduler #(
  parameter int NUM_COLUMNS    = 4,
  parameter int BASE_PERIOD    = 50000000,
  parameter int PERIOD_STEP    = 5000000,
  parameter int MIN_PERIOD     = 10000000,
  parameter int SPAWN_GAP      = 25000000,
  parameter int HITS_PER_LEVEL = 10
) (
  input logic clock,
  input logic reset_signal,
  column_scheduler_if.slave bus
);
  localparam int NC = NUM_COLUMNS;
  typedef enum logic [1:0] {IDLE, STAGGER, PLAYING, OVER} state_t;
  state_t        state_q, state_d;
  logic [NC-1:0] hold_q, hold_d, corr_q, hit;
  logic [31:0]   tick_q, tick_d, gap_q, gap_d, hits_q, hits_d, hit_sum, step, period;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   score_q, score_d;
  logic [16:0]   score_sum;
  logic [3:0]    level_q, level_d, pop;
  logic          fall_q, fall_d, active, over_hit;
  // next-state, release sequencing, tick generation and scoring
  always_comb begin
    step      = 32'(level_q) * 32'(PERIOD_STEP);
    period    = step >= 32'(BASE_PERIOD - MIN_PERIOD) ? 32'(MIN_PERIOD) : 32'(BASE_PERIOD) - step;
    active    = state_q == STAGGER || state_q == PLAYING;
    hit       = bus.col_correct & ~corr_q & ~hold_q;
    over_hit  = active && |(bus.col_game_over & ~hold_q);
    pop       = '0;
    for (int i = 0; i < NC; i++) pop = pop + 4'(hit[i]);
    score_sum = {1'b0, score_q} + 17'(pop);
    hit_sum   = hits_q + 32'(pop);
    state_d   = state_q;
    hold_d    = hold_q;
    tick_d    = '0;
    gap_d     = gap_q;
    idx_d     = idx_q;
    score_d   = score_q;
    level_d   = level_q;
    hits_d    = hits_q;
    fall_d    = 1'b0;
    if (over_hit) begin
      state_d = OVER;
      hold_d  = '1;
    end else if (active) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      hits_d  = hit_sum >= 32'(HITS_PER_LEVEL) ? hit_sum - 32'(HITS_PER_LEVEL) : hit_sum;
      level_d = (hit_sum >= 32'(HITS_PER_LEVEL) && level_q != 4'd15) ? level_q + 4'd1 : level_q;
      if (state_q == STAGGER) begin
        gap_d = gap_q + 32'd1;
        if (gap_q == 32'(SPAWN_GAP - 1)) begin
          gap_d  = '0;
          hold_d = hold_q & ~(NC'(1) << idx_q);
          idx_d  = idx_q + 3'd1;
          state_d = idx_q == 3'(NC - 1) ? PLAYING : STAGGER;
        end
      end else begin
        fall_d = tick_q >= period - 32'd1;
        tick_d = fall_d ? '0 : tick_q + 32'd1;
      end
    end else if (bus.start) begin
      state_d = NC == 1 ? PLAYING : STAGGER;
      hold_d  = ~NC'(1);
      gap_d   = '0;
      idx_d   = 3'd1;
      score_d = '0;
      level_d = '0;
      hits_d  = '0;
    end
  end
  // state and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q <= IDLE;
      hold_q  <= '1;
      corr_q  <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      hits_q  <= '0;
      idx_q   <= '0;
      score_q <= '0;
      level_q <= '0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      corr_q  <= bus.col_correct;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      hits_q  <= hits_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end
  assign bus.col_hold  = hold_q;
  assign bus.fall_tick = fall_q;
  assign bus.score     = score_q;
  assign bus.level     = level_q;
  assign bus.state     = state_q;
  assign bus.game_over = state_q == OVER;
endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler: directed stimulus checked against a cycle-timestamp game model plus literal pins
module tb_column_scheduler;
  localparam int N = 4, BASE = 20, STEP = 4, MINP = 8, GAP = 5, H = 3;
  logic clk, rst;
  column_scheduler_if #(.NUM_COLUMNS(N)) bus ();
  column_scheduler #(
    .NUM_COLUMNS(N), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP),
    .MIN_PERIOD(MINP), .SPAWN_GAP(GAP), .HITS_PER_LEVEL(H)
  ) dut (
    .clock(clk),
    .reset_signal(rst),
    .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  int errors = 0, checks = 0, cyc = 0;
  bit chk_en = 0;
  int m_state = 0, m_start = 0, m_score = 0, m_level = 0, m_hits = 0, m_ref = 0, m_fall = 0;
  logic [N-1:0] m_prev = '0;
  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int m_period(int lvl);
    int p = BASE - lvl * STEP;
    return p < MINP ? MINP : p;
  endfunction
  // a column is free once its release time (start + 1 + k*GAP) has passed
  function automatic logic [N-1:0] m_hold();
    logic [N-1:0] h = '1;
    if (m_state == 1 || m_state == 2)
      for (int k = 0; k < N; k++) if (cyc >= m_start + 1 + k * GAP) h[k] = 1'b0;
    return h;
  endfunction
  task automatic model_update();
    logic [N-1:0] rel, hv;
    int pop;
    rel = ~m_hold();
    hv  = bus.col_correct & ~m_prev & rel;
    pop = $countones(hv);
    m_fall = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_level = 0; m_hits = 0;
    end else if ((m_state == 1 || m_state == 2) && |(bus.col_game_over & rel)) begin
      m_state = 3;
    end else if (m_state == 1 || m_state == 2) begin
      if (m_state == 2 && cyc - m_ref >= m_period(m_level) - 1) begin
        m_fall = 1;
        m_ref = cyc + 1;
      end
      m_score = m_score + pop > 65535 ? 65535 : m_score + pop;
      m_hits += pop;
      if (m_hits >= H) begin
        m_hits -= H;
        if (m_level < 15) m_level++;
      end
      if (m_state == 1 && cyc + 1 == m_start + 1 + (N - 1) * GAP) begin
        m_state = 2;
        m_ref = cyc + 1;
      end
    end else if (bus.start) begin
      m_state = N == 1 ? 2 : 1;
      m_start = cyc;
      m_ref = cyc + 1;
      m_score = 0; m_level = 0; m_hits = 0;
    end
    m_prev = rst ? '0 : bus.col_correct;
    cyc++;
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic run_to(int t);
    while (cyc < t) tick();
  endtask
  task automatic pulse(logic [N-1:0] m);
    bus.col_correct = m;
    tick();
    bus.col_correct = '0;
    tick();
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("state", int'(bus.state), m_state);
    cmp("col_hold", int'(bus.col_hold), int'(m_hold()));
    cmp("fall_tick", int'(bus.fall_tick), m_fall);
    cmp("score", int'(bus.score), m_score);
    cmp("level", int'(bus.level), m_level);
    cmp("game_over", int'(bus.game_over), m_state == 3 ? 1 : 0);
  end
  initial begin
    int t0, found;
    rst = 1;
    bus.start = 0;
    bus.col_correct = '0;
    bus.col_game_over = '0;
    tick();
    chk_en = 1;
    tick();
    tick();
    cmp("rst_state", int'(bus.state), 0);
    cmp("rst_hold", int'(bus.col_hold), 4'b1111);
    cmp("rst_fall", int'(bus.fall_tick), 0);
    rst = 0;
    tick();
    t0 = cyc;
    bus.start = 1;
    tick();
    bus.start = 0;
    cmp("hold_c1", int'(bus.col_hold), 4'b1110);
    cmp("stagger_c1", int'(bus.state), 1);
    run_to(t0 + 6);
    cmp("hold_c6", int'(bus.col_hold), 4'b1100);
    run_to(t0 + 11);
    cmp("hold_c11", int'(bus.col_hold), 4'b1000);
    run_to(t0 + 15);
    cmp("stagger_c15", int'(bus.state), 1);
    run_to(t0 + 16);
    cmp("hold_c16", int'(bus.col_hold), 4'b0000);
    cmp("playing_c16", int'(bus.state), 2);
    run_to(t0 + 35);
    cmp("tick_c35", int'(bus.fall_tick), 0);
    run_to(t0 + 36);
    cmp("tick_c36", int'(bus.fall_tick), 1);
    run_to(t0 + 56);
    cmp("tick_c56", int'(bus.fall_tick), 1);
    repeat (3) pulse(4'b0010);
    cmp("score_3", int'(bus.score), 3);
    cmp("level_1", int'(bus.level), 1);
    run_to(t0 + 71);
    cmp("tick_c71", int'(bus.fall_tick), 0);
    run_to(t0 + 72);
    cmp("tick_c72", int'(bus.fall_tick), 1);
    run_to(t0 + 88);
    cmp("tick_c88", int'(bus.fall_tick), 1);
    repeat (15) pulse(4'b0010);
    cmp("score_18", int'(bus.score), 18);
    cmp("level_6", int'(bus.level), 6);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      found = int'(bus.fall_tick);
    end
    cmp("tick_found", found, 1);
    repeat (7) tick();
    cmp("floor_gap_low", int'(bus.fall_tick), 0);
    tick();
    cmp("floor_tick8", int'(bus.fall_tick), 1);
    bus.col_correct = 4'b0100;
    repeat (10) tick();
    bus.col_correct = '0;
    tick();
    cmp("held_score", int'(bus.score), 19);
    pulse(4'b1001);
    cmp("pair_score", int'(bus.score), 21);
    cmp("pair_level", int'(bus.level), 7);
    bus.col_correct = 4'b0001;
    bus.col_game_over = 4'b0010;
    tick();
    bus.col_correct = '0;
    bus.col_game_over = '0;
    cmp("over_state", int'(bus.state), 3);
    cmp("over_hold", int'(bus.col_hold), 4'b1111);
    cmp("over_score", int'(bus.score), 21);
    cmp("over_flag", int'(bus.game_over), 1);
    pulse(4'b0100);
    cmp("over_frozen", int'(bus.score), 21);
    cmp("over_fall", int'(bus.fall_tick), 0);
    t0 = cyc;
    bus.start = 1;
    tick();
    bus.start = 0;
    cmp("restart_state", int'(bus.state), 1);
    cmp("restart_score", int'(bus.score), 0);
    cmp("restart_level", int'(bus.level), 0);
    cmp("restart_hold", int'(bus.col_hold), 4'b1110);
    bus.col_game_over = 4'b1000;
    tick();
    bus.col_game_over = '0;
    cmp("held_over_ignored", int'(bus.state), 1);
    run_to(t0 + 16);
    cmp("replay_state", int'(bus.state), 2);
    repeat (7) pulse(4'b0010);
    cmp("pre_rst_score", int'(bus.score), 7);
    rst = 1;
    tick();
    cmp("midrst_state", int'(bus.state), 0);
    cmp("midrst_score", int'(bus.score), 0);
    cmp("midrst_level", int'(bus.level), 0);
    cmp("midrst_hold", int'(bus.col_hold), 4'b1111);
    rst = 0;
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
- Game-level controller for NUM_COLUMNS falling-letter columns.
- Sequences the game: idle, staggered column release, play, game over.
- Generates the shared fall tick, whose period shortens with level. Keeps score and level from per-column correct hits, and forces columns parked through per-column hold lines.
- Sits between the top level (start button, score/level display) and the column instances.

Parameters:
- NUM_COLUMNS, 4: number of columns controlled (1..8).
- BASE_PERIOD, 50000000: fall-tick period in cycles at level 0.
- PERIOD_STEP, 5000000: period reduction per level.
- MIN_PERIOD, 10000000: period floor; must be at least 2.
- SPAWN_GAP, 25000000: cycles between successive column releases in STAGGER.
- HITS_PER_LEVEL, 10: scored hits needed to advance one level.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_signal  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts or restarts a game; ignored in STAGGER/PLAYING.
- col_correct  in  NUM_COLUMNS  per-column "typed letter matches" flag (level).
- col_game_over  in  NUM_COLUMNS  per-column "letter reached bottom" flag (level).
- col_hold  out  NUM_COLUMNS  1 = column forced parked (drives column reset input).
- fall_tick  out  1  one-cycle pulse every current_period cycles; PLAYING only.
- score  out  16  scored hits, saturating at 16'hFFFF.
- level  out  4  current level, saturating at 15.
- state  out  2  0 IDLE, 1 STAGGER, 2 PLAYING, 3 OVER.
- game_over  out  1  high exactly when state==OVER.

Behaviour:
- Reset: state=IDLE; col_hold=all 1; fall_tick=0; score=0; level=0; game_over=0. All internal counters (tick, gap, hit, column index) and edge registers are 0. Reset has priority over every other input.
- current_period = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD), computed at 32 bits with no underflow (clamp before subtracting).
- Released mask: rel = ~col_hold. Only released columns are scored or can end the game.
- IDLE:
  - All holds 1.
  - On start: clear score, level and hit counter; set col_hold[0]=0; gap counter=0; go to STAGGER.
- STAGGER:
  - Gap counter increments each cycle.
  - When it reaches SPAWN_GAP-1: release the next column, clear the counter.
  - The cycle the last column is released, go to PLAYING.
  - If NUM_COLUMNS==1, go directly to PLAYING on the cycle after start.
  - fall_tick stays 0; the tick counter is held at 0.
- PLAYING:
  - Tick counter increments each cycle.
  - When it reaches current_period-1: fall_tick=1 for that cycle and the counter clears.
  - A period change caused by a level-up takes effect from the next count (compare is against the live value). If the counter is already at or above the new period-1, the tick fires on the next cycle.
- Scoring (STAGGER and PLAYING):
  - hit = col_correct & ~col_correct_q & rel, where col_correct_q is col_correct registered one cycle. Rising edge only: a held flag scores once.
  - score += popcount(hit), saturating.
  - Hit counter += popcount(hit). When it reaches or exceeds HITS_PER_LEVEL, subtract HITS_PER_LEVEL and increment level (max one level per cycle, saturating at 15).
- Game over:
  - If any (col_game_over & rel) in STAGGER or PLAYING: go to OVER next cycle; all holds 1; fall_tick 0.
  - Hits in that same cycle are NOT scored; game over wins.
  - score and level are frozen in OVER.
- OVER:
  - start behaves as in IDLE: clears score and level, enters STAGGER, releases column 0.
  - col_game_over of held columns is ignored in every state.
- Latency: start to col_hold[0]=0 is 1 cycle. Column k is released 1+k*SPAWN_GAP cycles after start.
- reset_signal mid-game returns to IDLE immediately (next edge), with outputs at reset values.

Test Plan:
- Test parameters: NUM_COLUMNS=4, BASE_PERIOD=20, PERIOD_STEP=4, MIN_PERIOD=8, SPAWN_GAP=5, HITS_PER_LEVEL=3.
- Reset then start pulse at cycle 0 -> col_hold 1110 at cycle 1, 1100 at 6, 1000 at 11, 0000 at 16; state=PLAYING at 16; first fall_tick 20 cycles later, then every 20.
- Three separate col_correct[1] rising edges in PLAYING -> score=3, level=1, tick spacing becomes 16. Five more level-ups -> period floors at 8, level=6.
- col_correct[2] held high 10 cycles -> score +1 only. col_correct[0] and [3] rising in the same cycle -> score +2.
- col_game_over[1] asserted with col_correct[0] rising in the same cycle -> state=OVER next cycle, col_hold=1111, score unchanged, fall_tick stays 0.
- In OVER, start -> score=0, level=0, STAGGER, col_hold=1110. col_game_over[3] asserted while column 3 is still held -> ignored.
- reset_signal asserted in PLAYING with score=7 -> next cycle IDLE, score=0, level=0, col_hold=1111.
